// File: rtl/ups_rst_seq.sv
// Sequenced multi-domain reset release with mode-change re-run.
// Optional watchdog is compiled in with `define UPS_RST_SEQ_WDT_EN.
module ups_rst_seq #(
    parameter int unsigned NUM_DOM  = 4,
    parameter int unsigned HOLD_CYC = 255,
    parameter int unsigned GAP_CYC  = 16,
    parameter int unsigned WDT_CYC  = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode_req,
    input  logic               wdt_kick,
    output logic [NUM_DOM-1:0] dom_rst_n,
    output logic               seq_busy,
    output logic               mode_ack,
    output logic               wdt_fault
);

    localparam int unsigned CNT_MAX_HG = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int unsigned CNT_MAX    = (CNT_MAX_HG > WDT_CYC) ? CNT_MAX_HG : WDT_CYC;
    localparam int unsigned CW         = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic            pending;

    // Saturating increment; the counter never wraps.
    always_comb begin
        cnt_inc = cnt;
        if (cnt != CW'(CNT_MAX)) begin
            cnt_inc = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ASSERT;
            cnt       <= '0;
            pending   <= 1'b0;
            dom_rst_n <= '0;
            seq_busy  <= 1'b1;
            mode_ack  <= 1'b0;
            wdt_fault <= 1'b0;
        end else begin
            mode_ack <= 1'b0;
            if (mode_req) begin
                // Re-assert everything; in ASSERT this just pins the hold count at 0.
                state     <= ST_ASSERT;
                cnt       <= '0;
                dom_rst_n <= '0;
                seq_busy  <= 1'b1;
                if (state != ST_ASSERT) begin
                    pending <= 1'b1;
                end
            end else begin
                case (state)
                    ST_ASSERT: begin
                        if (cnt_inc == CW'(HOLD_CYC)) begin
                            dom_rst_n <= NUM_DOM'(1);
                            cnt       <= '0;
                            state     <= ST_RELEASE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_RELEASE: begin
                        if (&dom_rst_n) begin
                            state    <= ST_RUN;
                            seq_busy <= 1'b0;
                            mode_ack <= pending;
                            pending  <= 1'b0;
                            cnt      <= '0;
                        end else if (cnt_inc == CW'(GAP_CYC)) begin
                            dom_rst_n <= (dom_rst_n << 1) | NUM_DOM'(1);
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_RUN: begin
`ifdef UPS_RST_SEQ_WDT_EN
                        // Timer measures cycles since the last kick or RUN entry.
                        if (wdt_kick) begin
                            cnt <= '0;
                        end else if (cnt_inc == CW'(WDT_CYC)) begin
                            wdt_fault <= 1'b1;
                            state     <= ST_ASSERT;
                            cnt       <= '0;
                            dom_rst_n <= '0;
                            seq_busy  <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
`else
                        cnt <= '0;
`endif
                    end
                    default: begin
                        state <= ST_ASSERT;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifndef UPS_RST_SEQ_WDT_EN
    logic unused_wdt_kick;
    assign unused_wdt_kick = wdt_kick;
`endif

endmodule

// File: doc/ups_rst_seq.md
UPS_RST_SEQ -- requirements
Module: ups_rst_seq

Interface
REQ-001 Parameter NUM_DOM, default 4, number of sequenced reset domains (1..8).
REQ-002 Parameter HOLD_CYC, default 255, cycles all domains are held in reset before the first release (>=1).
REQ-003 Parameter GAP_CYC, default 16, cycles between consecutive domain releases (>=1).
REQ-004 Parameter WDT_CYC, default 65535, watchdog timeout in cycles (>=2); used only with the watchdog compiled in.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 mode_req  input  1  level request to re-run the reset sequence (mode change).
REQ-008 wdt_kick  input  1  watchdog service strobe, one cycle per kick.
REQ-009 dom_rst_n  output  NUM_DOM  per-domain active-low resets; bit 0 is released first.
REQ-010 seq_busy  output  1  high whenever any domain is held in reset.
REQ-011 mode_ack  output  1  one-cycle pulse at completion of a sequence started by mode_req.
REQ-012 wdt_fault  output  1  sticky watchdog expiry flag.

Function
REQ-013 FSM states: ASSERT, RELEASE, RUN; all outputs registered.
- ASSERT: dom_rst_n all 0; counter counts HOLD_CYC edges.
- Edge 1 is the first rising edge with rst low.
REQ-014 ASSERT timing: dom_rst_n[0] is set to 1 at edge HOLD_CYC, and the FSM enters RELEASE at that edge.
REQ-015 RELEASE timing:
- dom_rst_n[i] is set to 1 exactly GAP_CYC edges after dom_rst_n[i-1].
- Released bits stay 1 until the next re-assert.
REQ-016 Completion: one edge after the last domain is released, the FSM enters RUN and seq_busy is set to 0.
- NUM_DOM=1: RUN is entered the edge after edge HOLD_CYC.
REQ-017 mode_req in RUN or RELEASE: at the next edge, all dom_rst_n go to 0, seq_busy goes to 1, the FSM enters ASSERT with counter 0, and a pending flag is set.
REQ-018 mode_req in ASSERT: holds the counter at 0; the HOLD_CYC count starts on the first edge after mode_req falls.
REQ-019 mode_ack pulses high for one cycle on the RUN-entry edge when pending is set, and pending clears on that edge.
- The power-up sequence never pulses mode_ack.
REQ-020 Counter width is clog2(max(HOLD_CYC, GAP_CYC, WDT_CYC)+1); the counter saturates and never wraps.
REQ-021 Priority when events coincide: rst > mode_req > watchdog expiry > normal counting.

Reset
REQ-022 rst high at any edge, including mid-sequence, forces on that edge:
- state ASSERT, counter 0, pending 0;
- dom_rst_n all 0, seq_busy 1, mode_ack 0, wdt_fault 0.
REQ-023 Outputs hold their reset values for as long as rst is high; counting begins at edge 1 after rst falls.

Configuration
REQ-024 Macro UPS_RST_SEQ_WDT_EN defined, watchdog behaviour:
- In RUN, a timer counts cycles since the last wdt_kick or RUN entry.
- After WDT_CYC cycles without a kick, wdt_fault sets and the FSM re-enters ASSERT exactly as for mode_req, but without setting pending.
- wdt_kick outside RUN is ignored.
REQ-025 Macro UPS_RST_SEQ_WDT_EN undefined:
- No watchdog logic; wdt_kick is ignored and wdt_fault is constant 0.
- All ports are still present.
REQ-026 wdt_fault clears only on rst.

Verification (NUM_DOM=4, HOLD_CYC=8, GAP_CYC=4, WDT_CYC=32)
REQ-027 Power-up: rst high 3 cycles then low -> dom_rst_n goes 0001 at edge 8, 0011 at 12, 0111 at 16, 1111 at 20; seq_busy falls at edge 21; mode_ack stays 0.
REQ-028 Single-cycle mode_req in RUN -> dom_rst_n=0000 and seq_busy=1 next edge; same release pattern relative to that edge; mode_ack high for exactly one cycle when seq_busy falls.
REQ-029 mode_req one cycle after dom_rst_n=0011 -> 0000 next edge; full 8-cycle hold restarts; 0001 appears 8 edges later.
REQ-030 mode_req held high 50 cycles -> dom_rst_n=0000 throughout; 0001 appears 8 edges after mode_req falls.
REQ-031 rst pulsed for 1 cycle while dom_rst_n=0111 -> 0000, seq_busy=1 and pending=0 at that edge; the sequence restarts; no mode_ack.
REQ-032 With UPS_RST_SEQ_WDT_EN: in RUN, no kicks -> wdt_fault=1 and dom_rst_n=0000 at edge 32 after RUN entry.
- Kicks every 20 cycles -> no fault.
- Without the macro: no kicks for 100 cycles -> wdt_fault=0 and dom_rst_n=1111.
